// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the mul/div sequencing controller
// Contents: controller state enum, engine op encoding, ALU opcodes for mul/div,
//           rstatus register index, default iteration count and counter width.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WB   = 2'd3
  } md_state_e;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam int DEFAULT_ITER  = 32;
  localparam int DEFAULT_CNT_W = 6;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// rtl/multdiv_ctrl_if.sv - decode/engine/write-back signal bundle of the mul/div controller
// Modport slave  : the controller (drives engine strobes, stall/busy, write-back request).
// Modport master : the surroundings (decode starts, engine flags, write-port grant).
// Signals: start_mul, start_div, rd_in, divisor_zero, md_ovf, md_rem_zero, wb_ready (to controller);
//          md_load, md_op, md_step, step_cnt, stall, busy, wb_valid, wb_rd, wb_exc, wb_rstatus (from it).
interface multdiv_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             start_mul;
  logic             start_div;
  logic [4:0]       rd_in;
  logic             divisor_zero;
  logic             md_ovf;
  logic             md_rem_zero;
  logic             md_load;
  logic             md_op;
  logic             md_step;
  logic [CNT_W-1:0] step_cnt;
  logic             stall;
  logic             busy;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic             wb_exc;
  logic [31:0]      wb_rstatus;

  modport slave (
    input  start_mul, start_div, rd_in, divisor_zero, md_ovf, md_rem_zero, wb_ready,
    output md_load, md_op, md_step, step_cnt, stall, busy, wb_valid, wb_rd, wb_exc, wb_rstatus
  );

  modport master (
    output start_mul, start_div, rd_in, divisor_zero, md_ovf, md_rem_zero, wb_ready,
    input  md_load, md_op, md_step, step_cnt, stall, busy, wb_valid, wb_rd, wb_exc, wb_rstatus
  );
endinterface

// File: rtl/multdiv_step_counter.sv
// rtl/multdiv_step_counter.sv - clearable iteration counter with terminal-count flag
// Ports: clk_i, rst_ni (async active-low), clr_i (synchronous clear, wins over en_i),
//        en_i (count up), cnt_o (current count), last_o (cnt_o == LAST).
module multdiv_step_counter #(
  parameter int WIDTH = 6,
  parameter int LAST  = 31
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequencing controller for the shared iterative mul/div engine
// Ports: clock, reset_n (async active-low), bus (multdiv_ctrl_if.slave).
// Optional build macro MULTDIV_EARLY_TERM_EN: a mul in RUN finishes as soon as the
// engine reports no remaining multiplier bits (md_rem_zero), skipping the remaining steps.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int ITER        = DEFAULT_ITER,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input logic           clock,
  input logic           reset_n,
  multdiv_ctrl_if.slave bus
);

  md_state_e  state_q, state_d;
  logic [4:0] rd_q, rd_d;
  logic       op_q, op_d;
  logic       exc_q, exc_d;

  logic             start_any;
  logic             early_term;
  logic             cnt_clr;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;

  logic        md_load;
  logic        md_step;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic        wb_exc;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rstatus;

  assign start_any = bus.start_mul | bus.start_div;

`ifdef MULTDIV_EARLY_TERM_EN
  // Only multiply can short-circuit; a divide always needs every quotient bit.
  assign early_term = (op_q == MD_OP_MUL) && bus.md_rem_zero;
`else
  logic unused_rem_zero;
  assign unused_rem_zero = bus.md_rem_zero;
  assign early_term      = 1'b0;
`endif

  multdiv_step_counter #(
    .WIDTH (CNT_W),
    .LAST  (ITER - 1)
  ) u_step_counter (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .clr_i  (cnt_clr),
    .en_i   (md_step),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    op_d       = op_q;
    exc_d      = exc_q;
    md_load    = 1'b0;
    md_step    = 1'b0;
    cnt_clr    = 1'b0;
    stall      = 1'b1;
    busy       = 1'b1;
    wb_valid   = 1'b0;
    wb_exc     = 1'b0;
    wb_rd      = 5'd0;
    wb_rstatus = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        // The issuing cycle itself must already hold the PC and F/D latch.
        stall = start_any;
        if (start_any) begin
          rd_d  = bus.rd_in;
          // mul wins when decode raises both starts together.
          op_d  = bus.start_mul ? MD_OP_MUL : MD_OP_DIV;
          exc_d = !bus.start_mul && bus.divisor_zero;
          state_d = (!bus.start_mul && bus.divisor_zero) ? ST_WB : ST_LOAD;
        end
      end

      ST_LOAD: begin
        md_load = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (early_term) begin
          state_d = ST_WB;
        end else begin
          md_step = 1'b1;
          if (cnt_last) begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        wb_valid = 1'b1;
        wb_exc   = exc_q | ((op_q == MD_OP_MUL) & bus.md_ovf);
        wb_rd    = wb_exc ? RSTATUS_REG : rd_q;
        if (wb_exc) begin
          wb_rstatus = (op_q == MD_OP_DIV) ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MUL);
        end
        if (bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 5'd0;
      op_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.md_load    = md_load;
  assign bus.md_op      = op_q;
  assign bus.md_step    = md_step;
  assign bus.step_cnt   = cnt;
  assign bus.stall      = stall;
  assign bus.busy       = busy;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rd      = wb_rd;
  assign bus.wb_exc     = wb_exc;
  assign bus.wb_rstatus = wb_rstatus;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - self-checking bench for multdiv_ctrl against a cycle-count reference model
module tb_multdiv_ctrl;

  localparam int ITER = 32;
`ifdef MULTDIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    int          load_cycle;
    int          loads;
    int          steps;
    int          wb_cycle;
    int          valid_cycles;
    logic [4:0]  wb_rd;
    logic        wb_exc;
    logic [31:0] wb_rstatus;
    logic        md_op;
    int          cnt_at_wb;
    bit          stable;
    bit          stall_ok;
    bit          idle_after;
  } obs_t;

  logic clock;
  logic reset_n;
  logic rz_arm;
  int   rz_k;
  int   n_cmp;
  int   n_bad;

  multdiv_ctrl_if #(.CNT_W(6)) bus ();

  multdiv_ctrl #(
    .ITER        (ITER),
    .CNT_W       (6),
    .RSTATUS_MUL (4),
    .RSTATUS_DIV (5)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Engine stand-in: once the multiplier has no bits left it stays that way.
  assign bus.md_rem_zero = rz_arm && (int'(bus.step_cnt) >= rz_k);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected behaviour from the rules: result latency is load + steps (+1 zero-detect cycle).
  function automatic obs_t model(input bit mul, input bit dz, input bit ovf,
                                 input logic [4:0] rd, input int delay, input int k);
    obs_t e;
    bit zero;
    bit early;
    bit exc;
    zero  = !mul && dz;
    early = EARLY && mul && (k >= 0) && (k < ITER);
    exc   = zero || (mul && ovf);
    e = '0;
    e.steps        = zero ? 0 : (early ? k : ITER);
    e.loads        = zero ? 0 : 1;
    e.load_cycle   = zero ? -1 : 1;
    e.wb_cycle     = zero ? 1 : 2 + e.steps + (early ? 1 : 0);
    e.valid_cycles = delay + 1;
    e.wb_exc       = exc;
    e.wb_rd        = exc ? 5'd30 : rd;
    e.wb_rstatus   = exc ? (mul ? 32'd4 : 32'd5) : 32'd0;
    e.md_op        = !mul;
    e.cnt_at_wb    = e.steps;
    e.stable       = 1'b1;
    e.stall_ok     = 1'b1;
    e.idle_after   = 1'b1;
    return e;
  endfunction

  task automatic run_op(input bit mul, input bit div, input bit dz, input bit ovf,
                        input logic [4:0] rd, input int delay, input int k,
                        input bit spur, output obs_t o);
    bit done;
    bit hs;
    int waited;
    o = '0;
    o.load_cycle = -1;
    o.wb_cycle   = -1;
    o.stable     = 1'b1;
    o.stall_ok   = 1'b1;
    done   = 1'b0;
    hs     = 1'b0;
    waited = 0;
    rz_arm = (k >= 0);
    rz_k   = k;
    @(negedge clock);
    bus.start_mul    = mul;
    bus.start_div    = div;
    bus.rd_in        = rd;
    bus.divisor_zero = dz;
    bus.md_ovf       = ovf;
    bus.wb_ready     = 1'b0;
    #1;
    if (bus.stall !== 1'b1) o.stall_ok = 1'b0;
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(posedge clock);
      #1;
      bus.start_mul    = 1'b0;
      bus.start_div    = 1'b0;
      bus.divisor_zero = 1'b0;
      if (spur && cyc == 5) begin
        bus.start_mul    = 1'b1;
        bus.start_div    = 1'b1;
        bus.divisor_zero = 1'b1;
      end
      @(negedge clock);
      if (hs) begin
        o.idle_after = !bus.stall && !bus.busy && !bus.wb_valid;
        bus.wb_ready = 1'b0;
        done = 1'b1;
      end else begin
        if (bus.stall !== 1'b1 || bus.busy !== 1'b1) o.stall_ok = 1'b0;
        if (bus.md_load === 1'b1) begin
          o.loads++;
          if (o.load_cycle < 0) o.load_cycle = cyc;
        end
        if (bus.md_step === 1'b1) o.steps++;
        if (bus.wb_valid === 1'b1) begin
          if (o.wb_cycle < 0) begin
            o.wb_cycle   = cyc;
            o.wb_rd      = bus.wb_rd;
            o.wb_exc     = bus.wb_exc;
            o.wb_rstatus = bus.wb_rstatus;
            o.md_op      = bus.md_op;
            o.cnt_at_wb  = int'(bus.step_cnt);
          end else if (bus.wb_rd !== o.wb_rd || bus.wb_exc !== o.wb_exc ||
                       bus.wb_rstatus !== o.wb_rstatus) begin
            o.stable = 1'b0;
          end
          o.valid_cycles++;
          if (waited >= delay) begin
            bus.wb_ready = 1'b1;
            hs = 1'b1;
          end else begin
            waited++;
          end
        end
      end
    end
    bus.wb_ready = 1'b0;
    bus.md_ovf   = 1'b0;
    rz_arm       = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_cmp++;
    if ({bus.md_load, bus.md_op, bus.md_step, bus.step_cnt, bus.stall, bus.busy,
         bus.wb_valid, bus.wb_rd, bus.wb_exc, bus.wb_rstatus} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got load=%b op=%b step=%b cnt=%0d stall=%b busy=%b v=%b rd=%0d exc=%b rs=%0d, want all 0",
               bus.md_load, bus.md_op, bus.md_step, bus.step_cnt, bus.stall, bus.busy,
               bus.wb_valid, bus.wb_rd, bus.wb_exc, bus.wb_rstatus);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.step_cnt !== 6'd0 || bus.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%b cnt=%0d stall=%b, want 0 0 0", bus.busy, bus.step_cnt, bus.stall);
    end
  endtask

  task automatic test_mul_basic();
    obs_t o, e;
    run_op(1, 0, 0, 0, 5'd7, 0, -1, 0, o);
    e = model(1, 0, 0, 5'd7, 0, -1);
    n_cmp++;
    if (o.load_cycle !== e.load_cycle) begin n_bad++; $display("FAIL mul_load_cycle: got %0d want %0d", o.load_cycle, e.load_cycle); end
    n_cmp++;
    if (o.steps !== e.steps) begin n_bad++; $display("FAIL mul_steps: got %0d want %0d", o.steps, e.steps); end
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle) begin n_bad++; $display("FAIL mul_wb_cycle: got %0d want %0d", o.wb_cycle, e.wb_cycle); end
    n_cmp++;
    if (o.wb_rd !== e.wb_rd || o.wb_exc !== e.wb_exc || o.wb_rstatus !== e.wb_rstatus) begin
      n_bad++; $display("FAIL mul_wb_fields: got rd=%0d exc=%b rs=%0d want rd=%0d exc=%b rs=%0d",
                        o.wb_rd, o.wb_exc, o.wb_rstatus, e.wb_rd, e.wb_exc, e.wb_rstatus);
    end
    n_cmp++;
    if (o.cnt_at_wb !== e.cnt_at_wb) begin n_bad++; $display("FAIL mul_step_cnt_end: got %0d want %0d", o.cnt_at_wb, e.cnt_at_wb); end
    n_cmp++;
    if (o.idle_after !== e.idle_after || o.stall_ok !== e.stall_ok) begin
      n_bad++; $display("FAIL mul_stall: got idle_after=%b stall_ok=%b want 1 1", o.idle_after, o.stall_ok);
    end
  endtask

  task automatic test_div_zero();
    obs_t o, e;
    run_op(0, 1, 1, 0, 5'd9, 0, -1, 0, o);
    e = model(0, 1, 0, 5'd9, 0, -1);
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle) begin n_bad++; $display("FAIL divz_wb_cycle: got %0d want %0d", o.wb_cycle, e.wb_cycle); end
    n_cmp++;
    if (o.loads !== e.loads || o.steps !== e.steps) begin
      n_bad++; $display("FAIL divz_engine_idle: got loads=%0d steps=%0d want %0d %0d", o.loads, o.steps, e.loads, e.steps);
    end
    n_cmp++;
    if (o.wb_rd !== e.wb_rd || o.wb_exc !== e.wb_exc || o.wb_rstatus !== e.wb_rstatus) begin
      n_bad++; $display("FAIL divz_wb_fields: got rd=%0d exc=%b rs=%0d want rd=%0d exc=%b rs=%0d",
                        o.wb_rd, o.wb_exc, o.wb_rstatus, e.wb_rd, e.wb_exc, e.wb_rstatus);
    end
  endtask

  task automatic test_mul_ovf();
    obs_t o, e;
    run_op(1, 0, 0, 1, 5'd12, 0, -1, 0, o);
    e = model(1, 0, 1, 5'd12, 0, -1);
    n_cmp++;
    if (o.wb_rd !== e.wb_rd || o.wb_exc !== e.wb_exc || o.wb_rstatus !== e.wb_rstatus) begin
      n_bad++; $display("FAIL mulovf_wb_fields: got rd=%0d exc=%b rs=%0d want rd=%0d exc=%b rs=%0d",
                        o.wb_rd, o.wb_exc, o.wb_rstatus, e.wb_rd, e.wb_exc, e.wb_rstatus);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    run_op(0, 1, 0, 0, 5'd21, 5, -1, 0, o);
    e = model(0, 0, 0, 5'd21, 5, -1);
    n_cmp++;
    if (o.valid_cycles !== e.valid_cycles) begin n_bad++; $display("FAIL bp_valid_cycles: got %0d want %0d", o.valid_cycles, e.valid_cycles); end
    n_cmp++;
    if (o.stable !== e.stable) begin n_bad++; $display("FAIL bp_stable: got %b want %b", o.stable, e.stable); end
    n_cmp++;
    if (o.stall_ok !== e.stall_ok || o.idle_after !== e.idle_after) begin
      n_bad++; $display("FAIL bp_stall: got stall_ok=%b idle_after=%b want 1 1", o.stall_ok, o.idle_after);
    end
    n_cmp++;
    if (o.wb_rd !== e.wb_rd || o.md_op !== e.md_op) begin
      n_bad++; $display("FAIL bp_rd_op: got rd=%0d op=%b want rd=%0d op=%b", o.wb_rd, o.md_op, e.wb_rd, e.md_op);
    end
  endtask

  task automatic test_rd_zero_and_both_starts();
    obs_t o, e;
    run_op(1, 1, 1, 0, 5'd0, 0, -1, 0, o);
    e = model(1, 1, 0, 5'd0, 0, -1);
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle || o.md_op !== e.md_op) begin
      n_bad++; $display("FAIL both_starts_mul_wins: got wb_cycle=%0d op=%b want %0d %b", o.wb_cycle, o.md_op, e.wb_cycle, e.md_op);
    end
    n_cmp++;
    if (o.wb_rd !== e.wb_rd || o.wb_exc !== e.wb_exc || o.valid_cycles !== e.valid_cycles) begin
      n_bad++; $display("FAIL rd_zero_wb: got rd=%0d exc=%b nvalid=%0d want %0d %b %0d",
                        o.wb_rd, o.wb_exc, o.valid_cycles, e.wb_rd, e.wb_exc, e.valid_cycles);
    end
  endtask

  task automatic test_reset_mid_op();
    obs_t o, e;
    bit seen;
    bit got_wb;
    @(negedge clock);
    bus.start_div    = 1'b1;
    bus.divisor_zero = 1'b0;
    bus.rd_in        = 5'd3;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clock);
      #1;
      bus.start_div = 1'b0;
      @(negedge clock);
      if (bus.md_step === 1'b1 && bus.step_cnt === 6'd12) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rst_mid_reach: got step_cnt=%0d want 12 within budget", bus.step_cnt); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.md_load, bus.md_op, bus.md_step, bus.step_cnt, bus.stall, bus.busy,
         bus.wb_valid, bus.wb_rd, bus.wb_exc, bus.wb_rstatus} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got op=%b step=%b cnt=%0d stall=%b busy=%b v=%b, want all 0",
               bus.md_op, bus.md_step, bus.step_cnt, bus.stall, bus.busy, bus.wb_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    got_wb = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) got_wb = 1'b1;
    end
    n_cmp++;
    if (got_wb) begin n_bad++; $display("FAIL rst_mid_no_wb: got activity after reset, want none"); end
    run_op(0, 1, 0, 0, 5'd17, 0, -1, 0, o);
    e = model(0, 0, 0, 5'd17, 0, -1);
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle || o.steps !== e.steps || o.wb_rd !== e.wb_rd) begin
      n_bad++; $display("FAIL rst_mid_rerun: got wb_cycle=%0d steps=%0d rd=%0d want %0d %0d %0d",
                        o.wb_cycle, o.steps, o.wb_rd, e.wb_cycle, e.steps, e.wb_rd);
    end
  endtask

  task automatic test_early_term();
    obs_t o, e;
    run_op(1, 0, 0, 0, 5'd11, 0, 3, 0, o);
    e = model(1, 0, 0, 5'd11, 0, 3);
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle || o.steps !== e.steps) begin
      n_bad++; $display("FAIL early_mul: got wb_cycle=%0d steps=%0d want %0d %0d", o.wb_cycle, o.steps, e.wb_cycle, e.steps);
    end
    n_cmp++;
    if (o.cnt_at_wb !== e.cnt_at_wb) begin n_bad++; $display("FAIL early_mul_cnt: got %0d want %0d", o.cnt_at_wb, e.cnt_at_wb); end
    run_op(0, 1, 0, 0, 5'd11, 0, 3, 0, o);
    e = model(0, 0, 0, 5'd11, 0, 3);
    n_cmp++;
    if (o.wb_cycle !== e.wb_cycle || o.steps !== e.steps) begin
      n_bad++; $display("FAIL early_div_full: got wb_cycle=%0d steps=%0d want %0d %0d", o.wb_cycle, o.steps, e.wb_cycle, e.steps);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit mul, div, dz, ovf, spur;
    logic [4:0] rd;
    int delay, k;
    for (int i = 0; i < 10; i++) begin
      mul   = $urandom_range(0, 1);
      div   = mul ? 1'($urandom_range(0, 1)) : 1'b1;
      dz    = $urandom_range(0, 1);
      ovf   = $urandom_range(0, 1);
      rd    = 5'($urandom_range(0, 31));
      delay = $urandom_range(0, 3);
      k     = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 40));
      e     = model(mul, dz, ovf, rd, delay, k);
      spur  = (e.wb_cycle > 6) && ($urandom_range(0, 1) == 1);
      run_op(mul, div, dz, ovf, rd, delay, k, spur, o);
      n_cmp++;
      if (o.wb_cycle !== e.wb_cycle) begin n_bad++; $display("FAIL rnd%0d_wb_cycle: got %0d want %0d", i, o.wb_cycle, e.wb_cycle); end
      n_cmp++;
      if (o.steps !== e.steps || o.loads !== e.loads) begin
        n_bad++; $display("FAIL rnd%0d_engine: got steps=%0d loads=%0d want %0d %0d", i, o.steps, o.loads, e.steps, e.loads);
      end
      n_cmp++;
      if (o.wb_rd !== e.wb_rd || o.wb_exc !== e.wb_exc || o.wb_rstatus !== e.wb_rstatus || o.md_op !== e.md_op) begin
        n_bad++; $display("FAIL rnd%0d_wb_fields: got rd=%0d exc=%b rs=%0d op=%b want rd=%0d exc=%b rs=%0d op=%b",
                          i, o.wb_rd, o.wb_exc, o.wb_rstatus, o.md_op, e.wb_rd, e.wb_exc, e.wb_rstatus, e.md_op);
      end
      n_cmp++;
      if (o.valid_cycles !== e.valid_cycles || o.stable !== e.stable || o.stall_ok !== e.stall_ok ||
          o.idle_after !== e.idle_after) begin
        n_bad++; $display("FAIL rnd%0d_handshake: got nvalid=%0d stable=%b stall_ok=%b idle=%b want %0d 1 1 1",
                          i, o.valid_cycles, o.stable, o.stall_ok, o.idle_after, e.valid_cycles);
      end
      if (e.loads != 0) begin
        n_cmp++;
        if (o.cnt_at_wb !== e.cnt_at_wb) begin n_bad++; $display("FAIL rnd%0d_cnt_end: got %0d want %0d", i, o.cnt_at_wb, e.cnt_at_wb); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rz_arm = 1'b0;
    rz_k = -1;
    bus.start_mul    = 1'b0;
    bus.start_div    = 1'b0;
    bus.rd_in        = 5'd0;
    bus.divisor_zero = 1'b0;
    bus.md_ovf       = 1'b0;
    bus.wb_ready     = 1'b0;
    test_reset();
    test_mul_basic();
    test_div_zero();
    test_mul_ovf();
    test_backpressure();
    test_rd_zero_and_both_starts();
    test_reset_mid_op();
    test_early_term();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
